// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_t;

  localparam int SETTLE_W = 4;

  function automatic int last_index(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable settle-time down-counter; zero flags the terminal count.
module sweep_settle_cnt
  import truth_table_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a combinational network, samples its output
// after a settle time and compares the captured truth table with a golden one.
//
// state     | meaning
// ST_IDLE   | waiting for start_i, drive_o parked at 0
// ST_SETTLE | vector on drive_o, counting down settle cycles
// ST_SAMPLE | capture dut_out_i into table_o[index]
// ST_DONE   | done_o pulse, mismatch_o updated
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 dut_out_i,
  input  logic [2**N_IN-1:0]   expected_i,
  output logic [N_IN-1:0]      drive_o,
  output logic                 busy_o,
  output logic [2**N_IN-1:0]   table_o,
  output logic                 done_o,
  output logic                 mismatch_o
);

  localparam logic [N_IN-1:0]     LAST_IDX   = N_IN'(last_index(N_IN));
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

  sweep_state_t    state;
  logic [N_IN-1:0] index;
  logic            cnt_load;
  logic            cnt_en;
  logic            cnt_zero;

  // Reload in IDLE and SAMPLE so every vector's settle window starts full.
  assign cnt_load = (state == ST_IDLE) || (state == ST_SAMPLE);
  assign cnt_en   = (state == ST_SETTLE);

  sweep_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (SETTLE_VAL),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      index      <= '0;
      drive_o    <= '0;
      busy_o     <= 1'b0;
      table_o    <= '0;
      done_o     <= 1'b0;
      mismatch_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          index   <= '0;
          drive_o <= '0;
          busy_o  <= 1'b0;
          if (start_i) begin
            table_o    <= '0;
            mismatch_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort_i) begin
            drive_o <= '0;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort_i) begin
            drive_o <= '0;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            table_o[index] <= dut_out_i;
            if (index == LAST_IDX) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              index   <= index + N_IN'(1);
              drive_o <= index + N_IN'(1);
              state   <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          mismatch_o <= (table_o != expected_i);
          drive_o    <= '0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
